// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU operation (EXEC, then WB) with an optional
// repeat loop for multi-cycle shift/add chains.
// Optional feature macro: ALU_SEQ_REPEAT_EN. When it is defined, the latched
// count selects count+1 EXEC/WB iterations. When it is undefined, exactly one
// iteration is performed and no repeat counter exists.
// All strobes are decoded from the state register, so an asynchronous reset
// removes them immediately.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] op,
  input  logic       dst,
  input  logic [2:0] count,
  input  logic       pre_carry,
  input  logic       pre_lt,
  input  logic       pre_z,
  output logic [7:0] op_out,
  output logic       alu_oe_n,
  output logic       a_r,
  output logic       b_r,
  output logic       fl_carry,
  output logic       fl_lt,
  output logic       fl_z,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_op;
  logic       r_dst;
  logic       w_rep_more;

`ifdef ALU_SEQ_REPEAT_EN
  logic [2:0] r_cnt;

  // Remaining extra iterations: loaded on accept, decremented on each looping WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cnt <= 3'd0;
    else if (r_state == S_IDLE && start)     r_cnt <= count;
    else if (r_state == S_WB && w_rep_more)  r_cnt <= r_cnt - 3'd1;
  end

  assign w_rep_more = (r_cnt != 3'd0);
`else
  logic w_unused_count;
  assign w_unused_count = ^count;
  assign w_rep_more     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Capture the opcode and target on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 8'h00;
      r_dst <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_op  <= op;
      r_dst <= dst;
    end
  end

  // Flags load only at the end of WB, so fl_carry chains into the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_carry <= 1'b0;
      fl_lt    <= 1'b0;
      fl_z     <= 1'b0;
    end else if (r_state == S_WB) begin
      fl_carry <= pre_carry;
      fl_lt    <= pre_lt;
      fl_z     <= pre_z;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next   = r_state;
    op_out   = r_op;
    alu_oe_n = 1'b1;
    a_r      = 1'b0;
    b_r      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        op_out = 8'h00;
        busy   = 1'b0;
        if (start) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        alu_oe_n = 1'b0;
        a_r      = ~r_dst;
        b_r      = r_dst;
        w_next   = w_rep_more ? S_EXEC : S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. It runs directed cases followed by randomized
// operations. Each transaction is modelled as a cycle timeline:
// an IDLE accept, then n x (EXEC, WB), then DONE, then IDLE.
// Here n is count+1 when ALU_SEQ_REPEAT_EN is defined and 1 otherwise.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op = 8'h00;
  logic       dst = 1'b0;
  logic [2:0] count = 3'd0;
  logic       pre_carry = 1'b0, pre_lt = 1'b0, pre_z = 1'b0;
  logic [7:0] op_out;
  logic       alu_oe_n, a_r, b_r, fl_carry, fl_lt, fl_z, busy, done;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_fl = 3'b000;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dst(dst), .count(count),
    .pre_carry(pre_carry), .pre_lt(pre_lt), .pre_z(pre_z),
    .op_out(op_out), .alu_oe_n(alu_oe_n), .a_r(a_r), .b_r(b_r),
    .fl_carry(fl_carry), .fl_lt(fl_lt), .fl_z(fl_z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".oe_n"}, alu_oe_n, 1);
    chk({tag, ".a_r"}, a_r, 0);
    chk({tag, ".b_r"}, b_r, 0);
    chk({tag, ".op_out"}, op_out, 8'h00);
    chk({tag, ".flags"}, {fl_carry, fl_lt, fl_z}, exp_fl);
  endtask

  // Called at the sample point of an IDLE cycle; returns at the sample point of
  // the IDLE cycle that follows DONE.
  task automatic run_op(input string tag, input logic [7:0] o, input logic d,
                        input logic [2:0] c, input logic [2:0] pre0, input bit noise);
    int n;
`ifdef ALU_SEQ_REPEAT_EN
    n = int'(c) + 1;
`else
    n = 1;
`endif
    chk_idle({tag, ".idle"});
    start = 1'b1; op = o; dst = d; count = c;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); // EXEC
      chk({tag, ".exec.busy"}, busy, 1);
      chk({tag, ".exec.op_out"}, op_out, o);
      chk({tag, ".exec.oe_n"}, alu_oe_n, 1);
      chk({tag, ".exec.strb"}, {a_r, b_r}, 2'b00);
      chk({tag, ".exec.done"}, done, 0);
      chk({tag, ".exec.flags"}, {fl_carry, fl_lt, fl_z}, exp_fl);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 8'($urandom); dst = 1'($urandom); count = 3'($urandom);
      {pre_carry, pre_lt, pre_z} = (i == 0) ? pre0 : 3'($urandom);
      @(negedge clk); // WB
      chk({tag, ".wb.oe_n"}, alu_oe_n, 0);
      chk({tag, ".wb.a_r"}, a_r, !d);
      chk({tag, ".wb.b_r"}, b_r, d);
      chk({tag, ".wb.op_out"}, op_out, o);
      chk({tag, ".wb.busy"}, busy, 1);
      chk({tag, ".wb.done"}, done, 0);
      chk({tag, ".wb.flags"}, {fl_carry, fl_lt, fl_z}, exp_fl);
      exp_fl = {pre_carry, pre_lt, pre_z};
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk); // DONE
    chk({tag, ".done.done"}, done, 1);
    chk({tag, ".done.busy"}, busy, 1);
    chk({tag, ".done.strb"}, {a_r, b_r}, 2'b00);
    chk({tag, ".done.oe_n"}, alu_oe_n, 1);
    chk({tag, ".done.flags"}, {fl_carry, fl_lt, fl_z}, exp_fl);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    {pre_carry, pre_lt, pre_z} = 3'($urandom);
    @(negedge clk); // IDLE
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Single op: start accepted on the first edge after reset release
    run_op("single", 8'h30, 1'b0, 3'd0, 3'b001, 1'b0);
    chk("single.fl_z", fl_z, 1);
    // Writeback to B
    run_op("wb_b", 8'hA8, 1'b1, 3'd0, 3'b110, 1'b0);
    // Repeat count (iterations follow the build configuration)
    run_op("rep2", 8'h48, 1'b0, 3'd2, 3'b100, 1'b0);
    run_op("rep7", 8'h58, 1'b0, 3'd7, 3'b010, 1'b0);

    // start held for six cycles: exactly two operations, second EXEC at cycle 5
    op = 8'h11; dst = 1'b0; count = 3'd0; {pre_carry, pre_lt, pre_z} = 3'b101;
    for (int cyc = 0; cyc < 10; cyc++) begin
      chk($sformatf("held.c%0d.busy", cyc), busy,
          (cyc inside {1, 2, 3, 5, 6, 7}) ? 1 : 0);
      chk($sformatf("held.c%0d.done", cyc), done, (cyc == 3 || cyc == 7) ? 1 : 0);
      chk($sformatf("held.c%0d.a_r", cyc), a_r, (cyc == 2 || cyc == 6) ? 1 : 0);
      start = (cyc <= 5);
      @(negedge clk);
    end
    exp_fl = 3'b101;
    chk_idle("held.end");

    // Reset during WB: strobe drops at once, no DONE afterwards
    start = 1'b1; op = 8'h22; dst = 1'b0; count = 3'd0;
    {pre_carry, pre_lt, pre_z} = 3'b111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst.wb.a_r", a_r, 1);
    #1 rst_n = 1'b0;
    #1;
    exp_fl = 3'b000;
    chk_idle("rst.async");
    @(negedge clk);
    chk_idle("rst.hold");
    rst_n = 1'b1;

    // Randomized operations with start noise while busy
    for (int k = 0; k < 24; k++) begin
      run_op($sformatf("rnd%0d", k), 8'($urandom), 1'($urandom), 3'($urandom),
             3'($urandom), 1'b1);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk_idle($sformatf("rnd%0d.gap", k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
